// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive deserializer: synchronizes rx, recovers LSB-first bytes and
// keeps sticky ready / framing-error / overrun flags until the controller clears them.
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       clear,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic             rx_meta_q, rx_s_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;

   // Both sync flops reset to the idle level so reset release never fakes a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      ready_d = ready_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      // Clear first; a frame completing in the same cycle overrides it below.
      if (clear) begin
         ready_d = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_BIT_LAST) begin
               sh_d  = {rx_s_q, sh_q[7:1]};
               cnt_d = '0;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s_q) begin
                  data_d  = sh_q;
                  ready_d = 1'b1;
                  if (ready_q && !clear) ovr_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data       = data_q;
   assign data_ready = ready_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit; expected frame
// outcomes go into a scoreboard queue and are popped when busy falls.
module tb_uart_rx_deserializer;

   localparam int CPB  = 16;
   localparam int HALF = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       rdy;
      logic       ferr;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       clear;
   logic [7:0] data;
   logic       data_ready, frame_err, overrun, busy;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    t0 = 0;
   int    rise_e;
   int    busy_gap;
   bit    done;
   bit    in_frame = 1'b0;
   string cur_tag;
   exp_t  sb_q[$];

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .clear      (clear),
      .data       (data),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic r, input logic f, input logic o);
      exp_t x;
      x.data = d;
      x.rdy  = r;
      x.ferr = f;
      x.ovr  = o;
      return x;
   endfunction

   task automatic compare_completion();
      exp_t x;
      if (sb_q.size() == 0) begin
         check({cur_tag, "_unexpected_done"}, 32'(sb_q.size()), 1);
      end else begin
         x = sb_q.pop_front();
         check({cur_tag, "_data"},       data,       x.data);
         check({cur_tag, "_data_ready"}, data_ready, x.rdy);
         check({cur_tag, "_frame_err"},  frame_err,  x.ferr);
         check({cur_tag, "_overrun"},    overrun,    x.ovr);
      end
   endtask

   // One cycle, sampled on the falling edge; tracks completion and busy inside a frame.
   task automatic tick();
      logic bprev, rprev;
      int   e;
      bprev = busy;
      rprev = data_ready;
      @(negedge clk);
      if (in_frame) begin
         e = cyc - t0;
         if (!rprev && data_ready && rise_e < 0) rise_e = e;
         if (!done && bprev && !busy) begin
            done = 1'b1;
            compare_completion();
         end else if (!done && e >= 3 && !busy) begin
            busy_gap++;
         end
      end
   endtask

   // clr_edge: edge (counted from the rx fall) at which clear is captured; 0 = none.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_edge,
                             input exp_t x, input string tag);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      sb_q.push_back(x);
      cur_tag  = tag;
      t0       = cyc;
      done     = 1'b0;
      busy_gap = 0;
      rise_e   = -1;
      in_frame = 1'b1;
      for (int n = 0; n < 10; n++) begin
         rx = bits[n];
         for (int k = 0; k < CPB; k++) begin
            tick();
            clear = (cyc + 1 - t0 == clr_edge);
         end
      end
      rx       = 1'b1;
      in_frame = 1'b0;
      check({tag, "_completed"}, 32'(done), 1);
      if (!done && sb_q.size() != 0) void'(sb_q.pop_front());
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      logic [9:0] bits;
      int         busy_hi;

      rst_n = 1'b0;
      rx    = 1'b1;
      clear = 1'b0;
      repeat (3) tick();
      check("rst_data",       data,       8'h00);
      check("rst_data_ready", data_ready, 0);
      check("rst_frame_err",  frame_err,  0);
      check("rst_overrun",    overrun,    0);
      check("rst_busy",       busy,       0);
      rst_n = 1'b1;
      repeat (5) tick();

      // Single frame: data_ready first seen after edge 155, so it is 1 at edge 156.
      send_frame(8'hA5, 1'b1, 0, mk(8'hA5, 1, 0, 0), "a5");
      check("a5_ready_latency", 32'(rise_e), 155);
      check("a5_busy_gap",      32'(busy_gap), 0);
      repeat (4) tick();
      pulse_clear();
      check("a5_clr_ready", data_ready, 0);
      check("a5_clr_data",  data,       8'hA5);
      repeat (4) tick();

      // Back-to-back frames, clear captured two edges after each completion.
      send_frame(8'h00, 1'b1, 157, mk(8'h00, 1, 0, 0), "b2b_00");
      send_frame(8'hFF, 1'b1, 157, mk(8'hFF, 1, 0, 0), "b2b_ff");
      send_frame(8'h3C, 1'b1, 157, mk(8'h3C, 1, 0, 0), "b2b_3c");
      check("b2b_overrun", overrun,    0);
      check("b2b_ready",   data_ready, 0);

      // Bad stop bit; the low tail afterwards is rejected as a glitch.
      send_frame(8'h55, 1'b0, 0, mk(8'h3C, 0, 1, 0), "bad_55");
      repeat (40) tick();
      check("bad_ferr_held", frame_err,  1);
      check("bad_ready",     data_ready, 0);
      check("bad_busy_idle", busy,       0);
      pulse_clear();
      check("bad_clr_ferr", frame_err, 0);
      repeat (4) tick();

      // Overrun, then clear coinciding with a good completion.
      send_frame(8'h11, 1'b1, 0,   mk(8'h11, 1, 0, 0), "ovr_11");
      send_frame(8'h22, 1'b1, 0,   mk(8'h22, 1, 0, 1), "ovr_22");
      send_frame(8'h33, 1'b1, 155, mk(8'h33, 1, 0, 0), "ovr_33_clr");
      repeat (4) tick();
      check("ovr_33_ready_kept", data_ready, 1);
      pulse_clear();
      check("ovr_clr_ready", data_ready, 0);
      repeat (4) tick();

      // 4-cycle low glitch: busy for the 8 cycles of START, then back to IDLE.
      busy_hi = 0;
      rx = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (busy) busy_hi++;
      end
      rx = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (busy) busy_hi++;
      end
      check("glitch_busy_cycles", 32'(busy_hi), 8);
      check("glitch_busy_end",    busy,       0);
      check("glitch_ready",       data_ready, 0);
      check("glitch_ferr",        frame_err,  0);
      check("glitch_data",        data,       8'h33);

      // Reset in the middle of data bit 4.
      bits = {1'b1, 8'h99, 1'b0};
      for (int n = 0; n < 5; n++) begin
         rx = bits[n];
         repeat (CPB) tick();
      end
      rx = bits[5];
      repeat (CPB / 2) tick();
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      rx    = 1'b1;
      tick();
      check("mid_rst_data",  data,       8'h00);
      check("mid_rst_ready", data_ready, 0);
      check("mid_rst_ferr",  frame_err,  0);
      check("mid_rst_ovr",   overrun,    0);
      check("mid_rst_busy",  busy,       0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_busy", busy, 0);
      send_frame(8'h7E, 1'b1, 0, mk(8'h7E, 1, 0, 0), "post_rst_7e");
      check("post_rst_sb_empty", 32'(sb_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel front end of the UART loader path. Samples the asynchronous `rx` line and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop). Presents each byte on `data` with a sticky `data_ready` flag, held until the UART controller pulses `clear` after writing the byte to RAM. Adds glitch rejection on the start bit, framing-error detection and overrun detection.

## Interface
- `CLKS_PER_BIT`, default 5208 (50 MHz / 9600 baud): clock cycles per bit; must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer division): cycles from start-edge detection to start-bit centre sample.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rx` input 1: serial line; idles high; asynchronous to `clk`.
- `clear` input 1: synchronous acknowledge; clears `data_ready`, `frame_err` and `overrun`.
- `data` output 8: last good received byte.
- `data_ready` output 1: sticky; a new byte is valid on `data`.
- `frame_err` output 1: sticky; the last frame had stop bit = 0.
- `overrun` output 1: sticky; a byte completed while `data_ready` was already 1.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. The synchronized value `rx_s` is the only use of `rx`.
- FSM states: IDLE, START, DATA, STOP. Counter `cnt` is wide enough for `CLKS_PER_BIT-1`. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- IDLE: when `rx_s`=0, go to START and set `cnt`=0.
- START: `cnt` increments each cycle. When `cnt`=`HALF_BIT-1`, sample `rx_s`:
  - If 0, go to DATA with `cnt`=0 and `idx`=0.
  - If 1 (glitch), return to IDLE with no flag change.
- DATA: when `cnt`=`CLKS_PER_BIT-1`, shift `rx_s` into `sh[7]` (right shift, so LSB-first arrives at `sh[0]`), set `cnt`=0, then:
  - If `idx`=7, go to STOP.
  - Otherwise increment `idx`.
- STOP: when `cnt`=`CLKS_PER_BIT-1`, sample `rx_s` and return to IDLE:
  - `rx_s`=1 (good frame): `data`←`sh`, `data_ready`←1. If `data_ready` was already 1 and `clear` is not asserted this cycle, also set `overrun`←1. The newer byte overwrites `data`.
  - `rx_s`=0 (bad frame): `frame_err`←1. `data` and `data_ready` are unchanged.
- `clear` in any state: next cycle `data_ready`, `frame_err` and `overrun` are 0. The exception is the simultaneous-event rule under Timing.
- `busy` is 1 in START, DATA and STOP.

## Timing
- Reset values: `data`=0x00, `data_ready`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE, `cnt`=0, `idx`=0, `sh`=0.
- Reset asserted mid-frame aborts the frame immediately. After release the block waits in IDLE for the next `rx_s` falling level. A line held low through reset release is treated as a new start bit; the glitch check then applies.
- Latency: let edge E0 be the first clock edge at which the second sync flop captures 0. State is START after E0+1.
  - Start sample at E0+1+`HALF_BIT`.
  - Data bit i is sampled `(i+1)*CLKS_PER_BIT` edges after the start sample.
  - Stop bit is sampled 9*`CLKS_PER_BIT` edges after the start sample.
  - `data_ready` is 1 in the cycle following the stop sample.
- Simultaneous `clear` and good-frame completion: completion wins. `data_ready`=1, `overrun` stays 0, `frame_err`=0.
- Simultaneous `clear` and bad-frame completion: `frame_err`=1, `data_ready`=0.
- Back-to-back frames: IDLE re-arms in the cycle after the stop sample. A start bit that directly follows the stop bit is accepted.
- Glitch rejection: a low pulse shorter than `HALF_BIT` cycles (after synchronization) never reaches DATA.

## Test plan
Benches use `CLKS_PER_BIT`=16, `HALF_BIT`=8.
- Send 0xA5 with a good stop bit, 16 clk/bit. Required:
  - `data`=0xA5 and `data_ready`=1 exactly 2+1+8+144+1 edges after the rx falling edge.
  - `busy` high throughout the frame.
- Three frames 0x00, 0xFF, 0x3C back-to-back with no idle gap, `clear` pulsed after each. Required: each byte read correctly; `overrun`=0.
- 0x55 with stop bit=0. Required: `frame_err`=1, `data_ready`=0, `data` holds its previous value. `clear` returns `frame_err` to 0.
- Send 0x11 and hold `clear`=0, then send 0x22. Required: `data`=0x22, `data_ready`=1, `overrun`=1. `clear` pulsed in the completion cycle of a third byte 0x33 leaves `data_ready`=1 and `overrun`=0.
- Low glitch of 4 cycles on idle `rx`. Required: `busy` pulses high and then returns to IDLE by the centre sample; no flags set.
- Assert `rst_n`=0 during bit 4 of a frame, then release. Required:
  - All outputs are at their reset values.
  - The next full frame 0x7E is received correctly.
